// File: rtl/muldiv_unit_if.sv
// Operand/result handshake bundle for the iterative RISC-V M-extension multiply/divide unit.
// flush rides with the handshake because it kills whatever transaction the bundle carries.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [2:0]      md_op;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output flush, in_valid, src_a, src_b, md_op, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  flush, in_valid, src_a, src_b, md_op, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RISC-V MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU: XLEN cycles per op, 0 for divide special cases.
// Result is held until out_ready; no new accept until the result is taken; flush aborts at the next edge.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     mag_q, mag_d;
    logic                is_div_q, is_div_d;
    logic                hi_q, hi_d;
    logic                rem_q, rem_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                out_valid_q, out_valid_d;

    logic                sgn_a, sgn_b, a_neg, b_neg, accept;
    logic [XLEN-1:0]     abs_a, abs_b;
    logic [XLEN:0]       mul_sum, div_trial, div_diff;
    logic                div_ge;
    logic [2*XLEN-1:0]   mul_next, div_next, acc_step, prod_signed;
    logic [XLEN-1:0]     div_mag, div_signed, fin_result;

    assign bus.in_ready  = (state_q == S_IDLE) && rst_n;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = (result_q == '0);

    // Operand decode: signed operands become magnitudes, the sign is re-applied on the way into DONE.
    always_comb begin
        sgn_a  = bus.md_op[2] ? !bus.md_op[0]
                              : (bus.md_op[1:0] == 2'b01) || (bus.md_op[1:0] == 2'b10);
        sgn_b  = bus.md_op[2] ? !bus.md_op[0] : (bus.md_op[1:0] == 2'b01);
        a_neg  = sgn_a && bus.src_a[XLEN-1];
        b_neg  = sgn_b && bus.src_b[XLEN-1];
        abs_a  = a_neg ? -bus.src_a : bus.src_a;
        abs_b  = b_neg ? -bus.src_b : bus.src_b;
        accept = bus.in_valid && (state_q == S_IDLE) && !bus.flush;
    end

    // One iteration of each datapath; the accumulator is shared between multiply and divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);
        mul_next  = {mul_sum, acc_q[XLEN-1:1]};

        div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_trial - {1'b0, mag_q};
        div_ge    = !div_diff[XLEN];
        div_next  = {(div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0]),
                     acc_q[XLEN-2:0], div_ge};

        acc_step  = is_div_q ? div_next : mul_next;

        prod_signed = neg_q ? -acc_step : acc_step;
        div_mag     = rem_q ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
        div_signed  = neg_q ? -div_mag : div_mag;
        if (is_div_q) begin
            fin_result = div_signed;
        end else begin
            fin_result = hi_q ? prod_signed[2*XLEN-1:XLEN] : prod_signed[XLEN-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mag_d       = mag_q;
        is_div_d    = is_div_q;
        hi_d        = hi_q;
        rem_d       = rem_q;
        neg_d       = neg_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;

        if (bus.flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        cnt_d    = '0;
                        is_div_d = bus.md_op[2];
                        hi_d     = (bus.md_op[1:0] != 2'b00);
                        rem_d    = bus.md_op[1];
                        // Remainder takes the dividend's sign; everything else takes sign(A)^sign(B).
                        neg_d    = (bus.md_op[2] && bus.md_op[1]) ? a_neg : (a_neg ^ b_neg);
                        if (bus.md_op[2]) begin
                            mag_d = abs_b;
                            acc_d = {{XLEN{1'b0}}, abs_a};
                        end else begin
                            mag_d = abs_a;
                            acc_d = {{XLEN{1'b0}}, abs_b};
                        end

                        if (bus.md_op[2] && (bus.src_b == '0)) begin
                            result_d    = bus.md_op[1] ? bus.src_a : '1;
                            state_d     = S_DONE;
                            out_valid_d = 1'b1;
                        end else if (bus.md_op[2] && !bus.md_op[0] &&
                                     (bus.src_a == MIN_NEG) && (bus.src_b == '1)) begin
                            result_d    = bus.md_op[1] ? '0 : MIN_NEG;
                            state_d     = S_DONE;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d = S_CALC;
                        end
                    end
                end

                S_CALC: begin
                    acc_d = acc_step;
                    cnt_d = cnt_q + CW'(1);
                    // The last iteration and the sign fix-up land on the same edge.
                    if (cnt_d == CW'(XLEN)) begin
                        result_d    = fin_result;
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                    end
                end

                S_DONE: begin
                    if (bus.out_ready) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                    end
                end

                default: begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mag_q       <= '0;
            is_div_q    <= 1'b0;
            hi_q        <= 1'b0;
            rem_q       <= 1'b0;
            neg_q       <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mag_q       <= mag_d;
            is_div_q    <= is_div_d;
            hi_q        <= hi_d;
            rem_q       <= rem_d;
            neg_q       <= neg_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int XLEN = 32;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;
    localparam logic [31:0] ALL1    = 32'hFFFF_FFFF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    muldiv_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: RISC-V M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          ps;
        longint unsigned pu;
        int              sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
            3'd1: begin ps = longint'(sa) * longint'(sb); return ps[63:32]; end
            3'd2: begin ps = longint'(sa) * longint'({32'b0, b}); return ps[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return ALL1;
                if (a == MIN_NEG && b == ALL1) return MIN_NEG;
                return sa / sb;
            end
            3'd5: return (b == 0) ? ALL1 : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_NEG && b == ALL1) return 32'd0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2] && (b == 0)) return 0;
        if (op[2] && !op[0] && a == MIN_NEG && b == ALL1) return 0;
        return XLEN;
    endfunction

    // Accept one op, wait for the result, hold it under backpressure, then consume it.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input int hold);
        logic [31:0] exp;
        int          n;
        exp = ref_result(op, a, b);
        bus.in_valid = 1'b1;
        bus.md_op    = op;
        bus.src_a    = a;
        bus.src_b    = b;
        tick();
        bus.in_valid = 1'b0;
        bus.md_op    = 3'($urandom_range(7));
        bus.src_a    = $urandom;
        bus.src_b    = $urandom;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(ref_latency(op, a, b)));
        check({tag, "_res"}, 64'(bus.result), 64'(exp));
        check({tag, "_zero"}, 64'(bus.zero), 64'(exp == 0));
        check({tag, "_inrdy_busy"}, 64'(bus.in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.md_op    = 3'($urandom_range(7));
            bus.src_a    = $urandom;
            bus.src_b    = $urandom;
            tick();
            check({tag, "_hold_res"}, 64'(bus.result), 64'(exp));
            check({tag, "_hold_vld"}, 64'(bus.out_valid), 64'd1);
            check({tag, "_hold_inrdy"}, 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_vld_drop"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_inrdy_back"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        int          stale;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.md_op     = 3'd0;
        bus.src_a     = '0;
        bus.src_b     = '0;
        bus.out_ready = 1'b0;

        // Reset values
        #12;
        check("rst_inrdy", 64'(bus.in_ready), 64'd0);
        check("rst_vld", 64'(bus.out_valid), 64'd0);
        check("rst_res", 64'(bus.result), 64'd0);
        check("rst_zero", 64'(bus.zero), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_inrdy", 64'(bus.in_ready), 64'd1);

        // Directed multiplies
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7x-3", 0);
        do_op(3'd1, MIN_NEG, MIN_NEG, "mulh_min", 1);
        do_op(3'd2, MIN_NEG, MIN_NEG, "mulhsu_min", 0);
        do_op(3'd3, MIN_NEG, MIN_NEG, "mulhu_min", 2);
        do_op(3'd1, ALL1, 32'd5, "mulh_-1x5", 0);

        // Directed divides
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_-7_2", 0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_-7_2", 0);
        do_op(3'd5, 32'd100, 32'd7, "divu_100_7", 0);
        do_op(3'd7, 32'd100, 32'd7, "remu_100_7", 0);
        do_op(3'd4, 32'd100, 32'hFFFF_FFF9, "div_100_-7", 0);

        // Divide special cases
        do_op(3'd4, 32'h1234_5678, 32'd0, "div_x_0", 0);
        do_op(3'd7, 32'd5, 32'd0, "remu_5_0", 0);
        do_op(3'd4, MIN_NEG, ALL1, "div_ovf", 0);
        do_op(3'd6, MIN_NEG, ALL1, "rem_ovf", 0);
        do_op(3'd5, MIN_NEG, ALL1, "divu_min_all1", 0);

        // Backpressure with junk stimulus on the input side
        do_op(3'd5, 32'd1000, 32'd3, "bp10", 10);

        // Flush in IDLE blocks an accept that would otherwise complete on the fast path
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        bus.md_op    = 3'd4;
        bus.src_a    = 32'd9;
        bus.src_b    = 32'd0;
        tick();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        check("flush_idle_vld", 64'(bus.out_valid), 64'd0);
        check("flush_idle_inrdy", 64'(bus.in_ready), 64'd1);

        // Flush at CALC cycle 5
        bus.in_valid = 1'b1;
        bus.md_op    = 3'd0;
        bus.src_a    = 32'h1234_5678;
        bus.src_b    = 32'h9ABC_DEF0;
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_calc_vld", 64'(bus.out_valid), 64'd0);
        check("flush_calc_inrdy", 64'(bus.in_ready), 64'd1);
        stale = 0;
        repeat (40) begin
            tick();
            if (bus.out_valid) stale++;
        end
        check("flush_calc_stale", 64'(stale), 64'd0);
        do_op(3'd0, 32'd3, 32'd4, "mul_3x4_after_flush", 0);

        // Flush while holding a result
        bus.in_valid = 1'b1;
        bus.md_op    = 3'd4;
        bus.src_a    = 32'd77;
        bus.src_b    = 32'd0;
        tick();
        bus.in_valid = 1'b0;
        check("flush_done_pre_vld", 64'(bus.out_valid), 64'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_done_vld", 64'(bus.out_valid), 64'd0);
        check("flush_done_inrdy", 64'(bus.in_ready), 64'd1);

        // Asynchronous reset mid-CALC
        bus.in_valid = 1'b1;
        bus.md_op    = 3'd0;
        bus.src_a    = 32'd11;
        bus.src_b    = 32'd13;
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_inrdy", 64'(bus.in_ready), 64'd0);
        check("arst_vld", 64'(bus.out_valid), 64'd0);
        check("arst_res", 64'(bus.result), 64'd0);
        check("arst_zero", 64'(bus.zero), 64'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_release_inrdy", 64'(bus.in_ready), 64'd1);
        do_op(3'd0, 32'd3, 32'd4, "mul_3x4_after_rst", 0);

        // Randomized ops, biased toward divide corner cases
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(7))
                0: rb = 32'd0;
                1: begin ra = MIN_NEG; rb = ALL1; end
                2: rb = 32'($urandom_range(15));
                3: ra = 32'($urandom_range(15));
                default: ;
            endcase
            do_op(rop, ra, rb, "rnd", $urandom_range(3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised multiply/divide unit that executes the RISC-V M-extension operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) beside the single-cycle integer ALU in the execute stage. Operands are accepted over a valid/ready handshake. Each operation takes one result bit per cycle, or resolves in a single cycle for divide special cases. The result is held until the consumer takes it, which lets the pipeline stall on multi-cycle operations. A flush input kills an in-flight operation on a branch or trap.

## Interface
- XLEN, 32: operand and result width. Must be even and at least 4.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  reset, asynchronous and active-low.
- FLUSH  in  1  synchronous abort of any operation in flight.
- IN_VALID  in  1  operands and op are valid this cycle.
- IN_READY  out  1  unit can accept a new operation.
- SRC_A  in  XLEN  operand A (multiplicand or dividend).
- SRC_B  in  XLEN  operand B (multiplier or divisor).
- MD_OP  in  3  op select, RISC-V funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- OUT_VALID  out  1  RESULT is valid.
- OUT_READY  in  1  consumer takes RESULT this cycle.
- RESULT  out  XLEN  operation result.
- ZERO  out  1  high when RESULT equals 0.

## Operation
- States:
  - IDLE: IN_READY=1.
  - CALC: iterating.
  - DONE: OUT_VALID=1.
- IN_READY is high only in IDLE and while RST_N is high. No overlap between operations.
- Accept: an IN_VALID&IN_READY edge latches SRC_A, SRC_B and MD_OP. Input changes after that edge have no effect.
- Sign handling:
  - Signed operands are converted to magnitudes and processed unsigned; the sign is applied to the final value.
  - MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU: both operands unsigned.
  - DIV and REM: both operands signed.
- Multiply:
  - Shift-add, one multiplier bit per CALC cycle, into a 2*XLEN product.
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits of the correctly signed 2*XLEN product.
- Divide:
  - Restoring, one quotient bit per CALC cycle.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
- Fast path: IDLE goes straight to DONE on the accept edge, with no CALC cycles, in these cases:
  - Divisor 0: DIV/DIVU return all ones; REM/REMU return SRC_A.
  - Signed overflow (A = -2^(XLEN-1), B = -1): DIV returns -2^(XLEN-1); REM returns 0.
- Iteration counter: width clog2(XLEN)+1. Cleared on accept; CALC exits when the counter reaches XLEN.
- DONE:
  - RESULT and OUT_VALID hold until OUT_READY=1.
  - The edge where OUT_VALID&OUT_READY are both high returns the unit to IDLE, with OUT_VALID low the next cycle.
  - No accept happens on that same edge (IN_READY was low). The earliest next accept is one cycle later.
- FLUSH:
  - In CALC or DONE, FLUSH forces IDLE at the next edge, drops OUT_VALID, and delivers no result.
  - In IDLE, FLUSH blocks acceptance that cycle.
  - FLUSH has priority over IN_VALID and OUT_READY.
- ZERO is combinational: (RESULT == 0).

## Timing
- Reset values (asynchronous, on RST_N low):
  - State IDLE, counter 0.
  - RESULT 0, ZERO 1, OUT_VALID 0.
  - IN_READY 0 while RST_N is low; 1 from the first cycle after release.
- Latency, with accept at edge k:
  - Iterative ops: the CALC iterations run at the edges k+1 through k+XLEN, and the edge k+XLEN moves the unit to DONE. OUT_VALID is first high in the cycle after edge k+XLEN.
  - Fast-path ops: OUT_VALID is first high in the cycle after edge k.
- The sign correction of RESULT is registered on the transition into DONE. RESULT is stable for the whole time OUT_VALID is high.
- Throughput: one operation per XLEN+2 cycles at best (iterative), or 2 cycles at best (fast path, OUT_READY tied high).
- Asynchronous reset mid-CALC or mid-DONE: immediate IDLE. The operation is lost and OUT_VALID drops at once.

## Test plan
- MUL 7*(-3): RESULT=0xFFFFFFEB, OUT_VALID exactly 32 cycles after the accept edge.
- MULH, MULHSU and MULHU with A=B=0x80000000:
  - MULH returns 0x40000000.
  - MULHSU returns 0xC0000000.
  - MULHU returns 0x40000000.
- DIV -7/2 gives 0xFFFFFFFD; REM -7/2 gives 0xFFFFFFFF; DIVU 100/7 gives 14; REMU 100/7 gives 2.
- Divide special cases, each with OUT_VALID one cycle after accept:
  - DIV x/0 gives 0xFFFFFFFF.
  - REMU 5/0 gives 5.
  - DIV 0x80000000/-1 gives 0x80000000.
  - REM 0x80000000/-1 gives 0 with ZERO=1.
- Backpressure: OUT_READY held low for 10 cycles after OUT_VALID rises. RESULT, OUT_VALID and IN_READY=0 stay stable, and new IN_VALID stimulus is ignored. One cycle after OUT_READY is raised, OUT_VALID=0 and IN_READY=1.
- FLUSH at CALC cycle 5, then a new MUL 3*4: no stale result appears, and RESULT=12. Repeat with RST_N pulsed low mid-CALC and check the reset values immediately.
